// File: rtl/readout_stream_buffer.sv
// Channel-select capture stage feeding a first-word fall-through FIFO that drains
// over valid/ready. Samples that cannot be stored are dropped and flagged sticky.
module readout_stream_buffer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N_SRC  = 2,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned SEL_W  = 1,
  parameter int unsigned LVL_W  = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic [SEL_W-1:0]        src_sel_i,
  input  logic [N_SRC*DATA_W-1:0] in_data_i,
  input  logic [N_SRC-1:0]        in_valid_i,
  input  logic                    flush_i,
  output logic [DATA_W-1:0]       out_data_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [LVL_W-1:0]        level_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic                    overflow_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic              sel_valid;
  logic [DATA_W-1:0] sel_data;
  logic              pop, push_req, push, drop, wr_en;
  logic [DATA_W-1:0] head_data;

  // Channel mux; an out-of-range index selects nothing.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (32'(src_sel_i) == i) begin
        sel_valid = in_valid_i[i];
        sel_data  = in_data_i[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state; the head register is loaded from the post-update read pointer,
  // bypassing the memory when that slot is being written this cycle.
  always_comb begin
    pop      = valid_q & out_ready_i;
    push_req = en_i & sel_valid;
    push     = push_req & (~full_q | pop);
    drop     = push_req & full_q & ~pop;
    wr_en    = push & ~flush_i;

    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
    ovf_d    = ovf_q | drop;

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
    end

    full_d  = (level_d == LVL_W'(DEPTH));
    empty_d = (level_d == '0);
    valid_d = (level_d != '0);

    if (wr_en && (wr_ptr_q == rd_ptr_d)) begin
      head_data = sel_data;
    end else begin
      head_data = mem_q[rd_ptr_d];
    end
    out_data_d = valid_d ? head_data : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      out_data_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      out_data_q <= out_data_d;
    end
  end

  // Storage is left uninitialised on reset.
  always_ff @(posedge clk_i) begin
    if (wr_en && !rst_i) begin
      mem_q[wr_ptr_q] <= sel_data;
    end
  end

  assign out_data_o  = out_data_q;
  assign out_valid_o = valid_q;
  assign level_o     = level_q;
  assign full_o      = full_q;
  assign empty_o     = empty_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_readout_stream_buffer.sv
// Bench for readout_stream_buffer: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations and a randomized phase.
module tb_readout_stream_buffer;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned N_SRC  = 2;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned LVL_W  = 4;

  logic                    clk;
  logic                    rst;
  logic                    en;
  logic [SEL_W-1:0]        src_sel;
  logic [N_SRC*DATA_W-1:0] in_data;
  logic [N_SRC-1:0]        in_valid;
  logic                    flush;
  logic [DATA_W-1:0]       out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [LVL_W-1:0]        level;
  logic                    full;
  logic                    empty;
  logic                    overflow;

  int n_checks = 0;
  int n_err    = 0;

  readout_stream_buffer #(
    .DATA_W(DATA_W), .N_SRC(N_SRC), .DEPTH(DEPTH), .SEL_W(SEL_W), .LVL_W(LVL_W)
  ) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .src_sel_i(src_sel), .in_data_i(in_data),
    .in_valid_i(in_valid), .flush_i(flush), .out_data_o(out_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .level_o(level),
    .full_o(full), .empty_o(empty), .overflow_o(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue holding the stored samples in order.
  logic [DATA_W-1:0] mq[$];
  logic              m_ovf = 1'b0;
  logic              chk_en = 1'b0;
  logic              m_pop, m_req, m_full;
  int                s_idx;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_ovf  = 1'b0;
      chk_en = 1'b1;
    end else if (flush) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      s_idx  = int'(src_sel);
      m_pop  = (mq.size() != 0) && out_ready;
      m_req  = en && (s_idx < int'(N_SRC)) && in_valid[s_idx];
      m_full = (mq.size() == int'(DEPTH));
      if (m_pop) void'(mq.pop_front());
      if (m_req) begin
        if (!m_full || m_pop) mq.push_back(in_data[s_idx*DATA_W +: DATA_W]);
        else m_ovf = 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("level",     32'(level),     32'(mq.size()));
      chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("out_data",  32'(out_data),  (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
      chk("full",      32'(full),      32'(mq.size() == int'(DEPTH)));
      chk("empty",     32'(empty),     32'(mq.size() == 0));
      chk("overflow",  32'(overflow),  32'(m_ovf));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [DATA_W-1:0] v);
    in_data[ch*DATA_W +: DATA_W] = v;
  endtask

  logic [DATA_W-1:0] drain_exp [8];

  initial begin
    rst = 1'b1; en = 1'b0; src_sel = '0; in_data = '0; in_valid = '0;
    flush = 1'b0; out_ready = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
    // Reset / idle state
    chk("t1_valid", 32'(out_valid), 32'd0);
    chk("t1_level", 32'(level), 32'd0);
    chk("t1_empty", 32'(empty), 32'd1);
    chk("t1_ovf",   32'(overflow), 32'd0);
    chk("t1_data",  32'(out_data), 32'd0);

    // Two pushes on ch0, held, then drained
    en = 1'b1; src_sel = 2'd0; in_valid = 2'b01;
    set_ch(0, 8'hA1); cyc();
    set_ch(0, 8'hB2); cyc();
    in_valid = 2'b00;
    chk("t2_level", 32'(level), 32'd2);
    chk("t2_head",  32'(out_data), 32'hA1);
    cyc();
    chk("t2_hold",  32'(out_data), 32'hA1);
    out_ready = 1'b1;
    chk("t2_pop0",  32'(out_data), 32'hA1);
    cyc();
    chk("t2_pop1",  32'(out_data), 32'hB2);
    cyc();
    chk("t2_empty", 32'(empty), 32'd1);

    // Alternating channels keep capture order
    out_ready = 1'b0;
    src_sel = 2'd0; in_valid = 2'b11; set_ch(0, 8'hC3); set_ch(1, 8'hD4); cyc();
    src_sel = 2'd1; cyc();
    in_valid = 2'b00; out_ready = 1'b1;
    chk("t3_pop0", 32'(out_data), 32'hC3);
    cyc();
    chk("t3_pop1", 32'(out_data), 32'hD4);
    cyc();
    chk("t3_empty", 32'(empty), 32'd1);

    // Capture disabled
    out_ready = 1'b0; en = 1'b0; in_valid = 2'b11;
    set_ch(0, 8'hE5); set_ch(1, 8'hF6);
    repeat (4) cyc();
    chk("t4_level", 32'(level), 32'd0);
    chk("t4_valid", 32'(out_valid), 32'd0);

    // Fill, overflow, push into full FIFO with simultaneous pop
    en = 1'b1; src_sel = 2'd0; in_valid = 2'b01;
    for (int i = 0; i < 8; i++) begin
      set_ch(0, 8'(8'h10 + i));
      cyc();
    end
    chk("t5_full",  32'(full), 32'd1);
    chk("t5_lvl8",  32'(level), 32'd8);
    chk("t5_noovf", 32'(overflow), 32'd0);
    set_ch(0, 8'h18); cyc();
    chk("t5_ovf",   32'(overflow), 32'd1);
    chk("t5_lvl",   32'(level), 32'd8);
    chk("t5_head",  32'(out_data), 32'h10);
    set_ch(0, 8'h19); out_ready = 1'b1; cyc();
    in_valid = 2'b00;
    chk("t5_lvl_pp", 32'(level), 32'd8);
    drain_exp = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h19};
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t5_drain%0d", i), 32'(out_data), 32'(drain_exp[i]));
      cyc();
    end
    chk("t5_empty", 32'(empty), 32'd1);
    chk("t5_ovf_sticky", 32'(overflow), 32'd1);

    // Flush wins over push; out-of-range select; reset mid-drain
    out_ready = 1'b0; in_valid = 2'b01; set_ch(0, 8'h33);
    repeat (3) cyc();
    chk("t6_lvl3", 32'(level), 32'd3);
    flush = 1'b1; cyc();
    flush = 1'b0; in_valid = 2'b00;
    chk("t6_flush_lvl",   32'(level), 32'd0);
    chk("t6_flush_ovf",   32'(overflow), 32'd0);
    chk("t6_flush_valid", 32'(out_valid), 32'd0);
    src_sel = 2'd3; in_valid = 2'b11;
    repeat (2) cyc();
    chk("t6_oor_lvl", 32'(level), 32'd0);
    src_sel = 2'd0; in_valid = 2'b01; set_ch(0, 8'h55);
    repeat (2) cyc();
    in_valid = 2'b00; out_ready = 1'b1; cyc();
    chk("t6_mid_lvl", 32'(level), 32'd1);
    rst = 1'b1; cyc();
    rst = 1'b0; out_ready = 1'b0;
    chk("t6_rst_lvl",   32'(level), 32'd0);
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_data",  32'(out_data), 32'd0);
    chk("t6_rst_empty", 32'(empty), 32'd1);

    // Randomized traffic with varying drain pressure
    for (int ph = 0; ph < 6; ph++) begin
      for (int c = 0; c < 500; c++) begin
        en        = ($urandom_range(0, 3) != 0);
        src_sel   = SEL_W'($urandom_range(0, 3));
        in_valid  = N_SRC'($urandom);
        in_data   = (N_SRC*DATA_W)'($urandom);
        out_ready = ($urandom_range(0, 5) < ph);
        flush     = ($urandom_range(0, 63) == 0);
        rst       = ($urandom_range(0, 255) == 0);
        cyc();
      end
    end
    rst = 1'b0; flush = 1'b0; en = 1'b0; in_valid = '0; out_ready = 1'b1;
    repeat (10) cyc();
    chk("final_empty", 32'(empty), 32'd1);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
